// File: rtl/mpsoc_gpio_input_conditioner_if.sv
// Pad-side bundle for the GPIO input conditioner: configuration and raw pads
// in, filtered level and edge pulses out.
interface mpsoc_gpio_input_conditioner_if #(
    parameter int PDATA_SIZE = 8,
    parameter int CNT_SIZE   = 16
);
    logic [CNT_SIZE-1:0]   cfg_thresh_i;
    logic [PDATA_SIZE-1:0] cfg_en_i;
    logic [PDATA_SIZE-1:0] pad_i;
    logic [PDATA_SIZE-1:0] gpio_q;
    logic [PDATA_SIZE-1:0] rise_o;
    logic [PDATA_SIZE-1:0] fall_o;

    modport master (
        output cfg_thresh_i, cfg_en_i, pad_i,
        input  gpio_q, rise_o, fall_o
    );

    modport slave (
        input  cfg_thresh_i, cfg_en_i, pad_i,
        output gpio_q, rise_o, fall_o
    );
endinterface

// File: rtl/mpsoc_gpio_input_conditioner.sv
// GPIO pad input conditioner: per-bit synchroniser, debounce filter with a
// shared stability threshold, and registered rise/fall pulses. The filtered
// level feeds mpsoc_apb4_gpio.gpio_i.
module mpsoc_gpio_input_conditioner #(
    parameter int PDATA_SIZE = 8,
    parameter int SYNC_DEPTH = 3,
    parameter int CNT_SIZE   = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    mpsoc_gpio_input_conditioner_if.slave bus
);
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

    logic [PDATA_SIZE-1:0] r_sync [SYNC_DEPTH];
    logic [PDATA_SIZE-1:0] r_gpio_q;
    logic [PDATA_SIZE-1:0] r_rise;
    logic [PDATA_SIZE-1:0] r_fall;
    logic [CNT_SIZE-1:0]   r_cnt [PDATA_SIZE];

    logic [PDATA_SIZE-1:0] w_s;
    logic [PDATA_SIZE-1:0] w_gpio_nxt;
    logic [CNT_SIZE-1:0]   w_cnt_nxt [PDATA_SIZE];

    assign w_s = r_sync[SYNC_DEPTH-1];

    // Synchroniser chain: flop-to-flop only, nothing between stages.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int k = 0; k < SYNC_DEPTH; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= bus.pad_i;
            for (int k = 1; k < SYNC_DEPTH; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    // Per-bit debounce decision. The count saturates at the threshold because
    // reaching it forces a commit, so no wrap even at the all-ones threshold.
    always_comb begin
        w_gpio_nxt = r_gpio_q;
        for (int i = 0; i < PDATA_SIZE; i++) begin
            w_cnt_nxt[i] = '0;
            if (!bus.cfg_en_i[i]) begin
                w_gpio_nxt[i] = w_s[i];
            end else if (w_s[i] != r_gpio_q[i]) begin
                if (r_cnt[i] >= bus.cfg_thresh_i) begin
                    w_gpio_nxt[i] = w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Filtered level, counters and one-cycle edge pulses; reset emits no pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_gpio_q <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < PDATA_SIZE; i++) r_cnt[i] <= '0;
        end else begin
            r_gpio_q <= w_gpio_nxt;
            r_rise   <= w_gpio_nxt & ~r_gpio_q;
            r_fall   <= ~w_gpio_nxt & r_gpio_q;
            for (int i = 0; i < PDATA_SIZE; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign bus.gpio_q = r_gpio_q;
    assign bus.rise_o = r_rise;
    assign bus.fall_o = r_fall;

endmodule

// File: tb/tb_mpsoc_gpio_input_conditioner.sv
// Bench for the GPIO input conditioner: a directed vector table, hand-written
// long-count / threshold-change / reset sequences, and a random run against
// a cycle-accurate reference model.
module tb_mpsoc_gpio_input_conditioner;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    mpsoc_gpio_input_conditioner_if #(.PDATA_SIZE(8), .CNT_SIZE(16)) bus ();

    mpsoc_gpio_input_conditioner #(
        .PDATA_SIZE(8),
        .SYNC_DEPTH(3),
        .CNT_SIZE(16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          rst;
        logic [7:0]  pad;
        logic [7:0]  en;
        logic [15:0] thr;
        int          cyc;
        logic [7:0]  q;
        logic [7:0]  rise;
        logic [7:0]  fall;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    bit          model_on = 1'b0;
    logic [7:0]  m_sync [3];
    logic [7:0]  m_q, m_rise, m_fall;
    logic [15:0] m_cnt [8];

    task automatic add_vec(input bit rst, input logic [7:0] pad, input logic [7:0] en,
                           input logic [15:0] thr, input int cyc, input logic [7:0] q,
                           input logic [7:0] rise, input logic [7:0] fall);
        vec_t v;
        v.rst = rst; v.pad = pad; v.en = en; v.thr = thr; v.cyc = cyc;
        v.q = q; v.rise = rise; v.fall = fall;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) m_sync[k] = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = '0;
        m_q = '0; m_rise = '0; m_fall = '0;
    endtask

    task automatic model_step();
        logic [7:0] s;
        logic [7:0] nq;
        s  = m_sync[2];
        nq = m_q;
        for (int i = 0; i < 8; i++) begin
            if (!bus.cfg_en_i[i]) begin
                nq[i] = s[i];
                m_cnt[i] = '0;
            end else if (s[i] == m_q[i]) begin
                m_cnt[i] = '0;
            end else if (m_cnt[i] >= bus.cfg_thresh_i) begin
                nq[i] = s[i];
                m_cnt[i] = '0;
            end else begin
                m_cnt[i] = m_cnt[i] + 16'd1;
            end
        end
        m_rise = nq & ~m_q;
        m_fall = ~nq & m_q;
        m_q    = nq;
        m_sync[2] = m_sync[1];
        m_sync[1] = m_sync[0];
        m_sync[0] = bus.pad_i;
    endtask

    task automatic tick();
        @(posedge PCLK);
        if (model_on) model_step();
        #1;
    endtask

    task automatic do_reset(input logic [7:0] pad, input logic [7:0] en, input logic [15:0] thr);
        PRESETn = 1'b0;
        bus.pad_i = pad;
        bus.cfg_en_i = en;
        bus.cfg_thresh_i = thr;
        model_clear();
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
    endtask

    initial begin
        bus.pad_i = '0;
        bus.cfg_en_i = '1;
        bus.cfg_thresh_i = 16'd4;
        #2;
        check("reset_q",    bus.gpio_q, 8'h00);
        check("reset_rise", bus.rise_o, 8'h00);
        check("reset_fall", bus.fall_o, 8'h00);

        // step on bit 0 with N=4: commits on the 8th cycle
        add_vec(1, 8'h00, 8'hFF, 16'd4, 2,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 7,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 1,  8'h01, 8'h01, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 1,  8'h01, 8'h00, 8'h00);
        // 4-cycle pulse on bit 1 rejected
        add_vec(0, 8'h03, 8'hFF, 16'd4, 4,  8'h01, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 10, 8'h01, 8'h00, 8'h00);
        // 5-cycle pulse on bit 1 commits, then the low commits back
        add_vec(0, 8'h03, 8'hFF, 16'd4, 5,  8'h01, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 2,  8'h01, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 1,  8'h03, 8'h02, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 4,  8'h03, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 1,  8'h01, 8'h00, 8'h02);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 1,  8'h01, 8'h00, 8'h00);
        // bypass: A5 then 5A
        add_vec(1, 8'hA5, 8'h00, 16'd4, 3,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'hA5, 8'h00, 16'd4, 1,  8'hA5, 8'hA5, 8'h00);
        add_vec(0, 8'hA5, 8'h00, 16'd4, 1,  8'hA5, 8'h00, 8'h00);
        add_vec(0, 8'h5A, 8'h00, 16'd4, 3,  8'hA5, 8'h00, 8'h00);
        add_vec(0, 8'h5A, 8'h00, 16'd4, 1,  8'h5A, 8'h5A, 8'hA5);
        add_vec(0, 8'h5A, 8'h00, 16'd4, 1,  8'h5A, 8'h00, 8'h00);
        // N=0: single-cycle filter, one-cycle glitch passes through
        add_vec(1, 8'h00, 8'hFF, 16'd0, 2,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'hFF, 8'hFF, 16'd0, 3,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'hFF, 8'hFF, 16'd0, 1,  8'hFF, 8'hFF, 8'h00);
        add_vec(0, 8'h7F, 8'hFF, 16'd0, 1,  8'hFF, 8'h00, 8'h00);
        add_vec(0, 8'hFF, 8'hFF, 16'd0, 3,  8'h7F, 8'h00, 8'h80);
        add_vec(0, 8'hFF, 8'hFF, 16'd0, 1,  8'hFF, 8'h80, 8'h00);
        // enable dropped mid-count: follows synced level next cycle
        add_vec(1, 8'h00, 8'hFF, 16'd4, 2,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd4, 5,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'h00, 16'd4, 1,  8'h01, 8'h01, 8'h00);
        // threshold raised mid-count: counts on to the new value
        add_vec(1, 8'h00, 8'hFF, 16'd2, 2,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd2, 4,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd6, 5,  8'h00, 8'h00, 8'h00);
        add_vec(0, 8'h01, 8'hFF, 16'd6, 1,  8'h01, 8'h01, 8'h00);

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst) begin
                do_reset(vecs[v].pad, vecs[v].en, vecs[v].thr);
            end else begin
                bus.pad_i = vecs[v].pad;
                bus.cfg_en_i = vecs[v].en;
                bus.cfg_thresh_i = vecs[v].thr;
            end
            repeat (vecs[v].cyc) tick();
            check($sformatf("vec%0d_q", v),    bus.gpio_q, vecs[v].q);
            check($sformatf("vec%0d_rise", v), bus.rise_o, vecs[v].rise);
            check($sformatf("vec%0d_fall", v), bus.fall_o, vecs[v].fall);
        end

        // threshold lowered mid-count (cnt=50 of 100) commits next cycle
        do_reset(8'h00, 8'hFF, 16'd100);
        repeat (2) tick();
        bus.pad_i = 8'h01;
        repeat (53) tick();
        check("lower_thr_before", bus.gpio_q, 8'h00);
        bus.cfg_thresh_i = 16'd10;
        tick();
        check("lower_thr_q",    bus.gpio_q, 8'h01);
        check("lower_thr_rise", bus.rise_o, 8'h01);

        // reset mid-count: outputs clear with no pulse; held-high pad rises normally after
        do_reset(8'h00, 8'hFF, 16'd4);
        repeat (2) tick();
        bus.pad_i = 8'h01;
        repeat (8) tick();
        check("midrst_pre_q", bus.gpio_q, 8'h01);
        bus.pad_i = 8'h00;
        repeat (5) tick();
        PRESETn = 1'b0;
        bus.pad_i = 8'h01;
        #1;
        check("midrst_async_q",    bus.gpio_q, 8'h00);
        check("midrst_async_rise", bus.rise_o, 8'h00);
        check("midrst_async_fall", bus.fall_o, 8'h00);
        tick();
        PRESETn = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("midrst_c%0d_q", c),    bus.gpio_q, 8'h00);
            check($sformatf("midrst_c%0d_rf", c),   bus.rise_o | bus.fall_o, 8'h00);
        end
        tick();
        check("midrst_rise_q", bus.gpio_q, 8'h01);
        check("midrst_rise",   bus.rise_o, 8'h01);

        // maximum threshold on bit 2: commit after 65536 mismatching cycles, no wrap
        do_reset(8'h00, 8'h04, 16'hFFFF);
        repeat (2) tick();
        bus.pad_i = 8'h04;
        repeat (65538) tick();
        check("maxthr_before_q", bus.gpio_q, 8'h00);
        tick();
        check("maxthr_q",    bus.gpio_q, 8'h04);
        check("maxthr_rise", bus.rise_o, 8'h04);
        repeat (100) tick();
        check("maxthr_hold_q",  bus.gpio_q, 8'h04);
        check("maxthr_hold_rf", bus.rise_o | bus.fall_o, 8'h00);

        // random pads with random hold widths against the reference model
        do_reset(8'h00, 8'hFF, 16'd3);
        model_on = 1'b1;
        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 500 == 0) begin
                    bus.cfg_en_i = 8'($urandom);
                    bus.cfg_thresh_i = 16'($urandom_range(0, 5));
                end
                if (hold == 0) begin
                    bus.pad_i = 8'($urandom);
                    hold = int'($urandom_range(1, 7));
                end
                hold--;
                tick();
                check("rand_q",    bus.gpio_q, m_q);
                check("rand_rise", bus.rise_o, m_rise);
                check("rand_fall", bus.fall_o, m_fall);
                check("rand_excl", bus.rise_o & bus.fall_o, 8'h00);
            end
        end
        model_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
